// File: rtl/fft_pkg.sv
// Shared types for the 4-point DFT accumulator sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fft_pkg;

    localparam int N_POINTS = 4;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // How one channel uses the current sample: add it, subtract it, or add nothing
    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_POS  = 2'd1,
        CLS_NEG  = 2'd2
    } tw_cls_t;

endpackage

// File: rtl/fft4_twiddle_sel.sv
// Twiddle class lookup: maps (bin k, term t) onto a class for each channel.
// Latency: combinational.
// Backpressure: none; pure decode.
module fft4_twiddle_sel
    import fft_pkg::*;
(
    input  logic [1:0] i_k,
    input  logic [1:0] i_t,
    output logic [1:0] o_re_cls,
    output logic [1:0] o_im_cls
);

    // Twiddle exponent (t*k) mod 4; a 2-bit product wraps modulo 4 naturally
    logic [1:0] w_m;
    assign w_m = i_t * i_k;

    // W^m for m=0..3 is 1, -j, -1, +j: each term lands on exactly one channel
    always_comb begin
        o_re_cls = CLS_ZERO;
        o_im_cls = CLS_ZERO;
        case (w_m)
            2'd0:    o_re_cls = CLS_POS;
            2'd1:    o_im_cls = CLS_NEG;
            2'd2:    o_re_cls = CLS_NEG;
            default: o_im_cls = CLS_POS;
        endcase
    end

endmodule

// File: rtl/fft4_acc_sequencer.sv
// Collects 4 samples, then drives two accumulators with 4 add/sub terms per DFT bin.
// Latency: bin 0 valid 5 cycles after the 4th sample; each later bin 5 cycles after acceptance.
// Backpressure: in_ready low outside IDLE; bins held (accumulators frozen) until bin_ready.
module fft4_acc_sequencer
    import fft_pkg::*;
#(
    parameter int SAMPLE_W = 8,
    parameter int ACC_W    = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [SAMPLE_W-1:0] in_data,
    output logic                in_ready,
    output logic                acc_enable,
    output logic                acc_load,
    output logic [ACC_W-1:0]    acc_data_load,
    output logic [ACC_W-1:0]    re_data_in,
    output logic                re_cin,
    output logic [ACC_W-1:0]    im_data_in,
    output logic                im_cin,
    output logic                bin_valid,
    output logic [1:0]          bin_idx,
    input  logic                bin_ready,
    output logic                frame_done
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_cnt;
    logic [1:0]          r_k;
    logic [1:0]          r_t;
    logic [SAMPLE_W-1:0] r_buf [N_POINTS];

    logic                w_accept;
    logic [ACC_W-1:0]    w_xs;
    logic [1:0]          w_re_cls;
    logic [1:0]          w_im_cls;

    assign w_accept = (r_state == ST_IDLE) && in_valid;
    assign w_xs     = {{(ACC_W-SAMPLE_W){r_buf[r_t][SAMPLE_W-1]}}, r_buf[r_t]};
    assign bin_idx  = r_k;

    fft4_twiddle_sel u_twiddle (
        .i_k      (r_k),
        .i_t      (r_t),
        .o_re_cls (w_re_cls),
        .o_im_cls (w_im_cls)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sample buffer and the cnt/k/t counters; all wrap to 0 at the end of their range
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= 2'd0;
            r_k   <= 2'd0;
            r_t   <= 2'd0;
            for (int i = 0; i < N_POINTS; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_buf[r_cnt] <= in_data;
                        r_cnt        <= r_cnt + 2'd1;
                        r_k          <= 2'd0;
                        r_t          <= 2'd0;
                    end
                end
                ST_RUN: begin
                    r_t <= r_t + 2'd1;
                end
                ST_HOLD: begin
                    if (bin_ready) begin
                        r_k <= r_k + 2'd1;
                        r_t <= 2'd0;
                        if (r_k == 2'd3) begin
                            r_cnt <= 2'd0;
                        end
                    end
                end
                default: begin
                    r_cnt <= 2'd0;
                    r_k   <= 2'd0;
                    r_t   <= 2'd0;
                end
            endcase
        end
    end

    // Next state and all outputs; acc_* depend only on registered state
    always_comb begin
        w_state_nxt   = r_state;
        in_ready      = 1'b0;
        acc_enable    = 1'b0;
        acc_load      = 1'b0;
        acc_data_load = '0;
        re_data_in    = '0;
        re_cin        = 1'b0;
        im_data_in    = '0;
        im_cin        = 1'b0;
        bin_valid     = 1'b0;
        frame_done    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (w_accept && (r_cnt == 2'd3)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_enable = 1'b1;
                acc_load   = (r_t == 2'd0);
                case (w_re_cls)
                    CLS_POS: re_data_in = w_xs;
                    CLS_NEG: begin
                        re_data_in = w_xs;
                        re_cin     = 1'b1;
                    end
                    default: re_data_in = '0;
                endcase
                case (w_im_cls)
                    CLS_POS: im_data_in = w_xs;
                    CLS_NEG: begin
                        im_data_in = w_xs;
                        im_cin     = 1'b1;
                    end
                    default: im_data_in = '0;
                endcase
                if (r_t == 2'd3) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                bin_valid = 1'b1;
                if (bin_ready) begin
                    if (r_k == 2'd3) begin
                        frame_done  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fft4_acc_sequencer.sv
// Bench for fft4_acc_sequencer: two behavioural accumulators, table + random frames.
// Latency: n/a.
// Backpressure: exercises bin_ready stalls and in_valid outside IDLE.
module tb_fft4_acc_sequencer;

    localparam int SW = 8;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [SW-1:0] in_data;
    logic          in_ready;
    logic          acc_enable;
    logic          acc_load;
    logic [AW-1:0] acc_data_load;
    logic [AW-1:0] re_data_in;
    logic          re_cin;
    logic [AW-1:0] im_data_in;
    logic          im_cin;
    logic          bin_valid;
    logic [1:0]    bin_idx;
    logic          bin_ready;
    logic          frame_done;

    logic [AW-1:0] acc_re;
    logic [AW-1:0] acc_im;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_re [4];
    int exp_im [4];
    int leak;
    int dl_nz;

    typedef struct {
        logic [3:0][7:0] x;
        int              re [4];
        int              im [4];
    } vec_t;
    vec_t vecs [4];

    always #5 clk = ~clk;

    fft4_acc_sequencer #(.SAMPLE_W(SW), .ACC_W(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .acc_enable    (acc_enable),
        .acc_load      (acc_load),
        .acc_data_load (acc_data_load),
        .re_data_in    (re_data_in),
        .re_cin        (re_cin),
        .im_data_in    (im_data_in),
        .im_cin        (im_cin),
        .bin_valid     (bin_valid),
        .bin_idx       (bin_idx),
        .bin_ready     (bin_ready),
        .frame_done    (frame_done)
    );

    // Downstream accumulator pair: load base (or keep), then add or subtract the term
    always @(posedge clk) begin
        if (acc_enable) begin
            acc_re <= (acc_load ? acc_data_load : acc_re) + (re_cin ? (~re_data_in + 10'd1) : re_data_in);
            acc_im <= (acc_load ? acc_data_load : acc_im) + (im_cin ? (~im_data_in + 10'd1) : im_data_in);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference DFT: X[k] = sum x[n] * (cos(2*pi*kn/4) - j*sin(2*pi*kn/4))
    function automatic void ref_dft(input logic [3:0][7:0] x);
        int cosv [4];
        int sinv [4];
        cosv = '{1, 0, -1, 0};
        sinv = '{0, 1, 0, -1};
        for (int k = 0; k < 4; k++) begin
            exp_re[k] = 0;
            exp_im[k] = 0;
            for (int n = 0; n < 4; n++) begin
                exp_re[k] += int'($signed(x[n])) * cosv[(k * n) % 4];
                exp_im[k] -= int'($signed(x[n])) * sinv[(k * n) % 4];
            end
        end
    endfunction

    task automatic send_sample(input logic [7:0] v);
        int w;
        w = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = v;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Step negedges until bin_valid, tallying acc activity; bounded
    task automatic wait_bin(output int cyc, output int en, output int ld);
        cyc = 0;
        en  = 0;
        ld  = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (acc_enable) en++;
            if (acc_load) ld++;
            if (in_ready) leak++;
            if (acc_data_load != '0) dl_nz++;
        end while (!bin_valid && cyc < 60);
    endtask

    task automatic check_bin(input int k, input int cyc_exp, input int cyc, input int en, input int ld);
        check($sformatf("bin%0d_valid", k), int'(bin_valid), 1);
        check($sformatf("bin%0d_idx", k), int'(bin_idx), k);
        check($sformatf("bin%0d_re", k), int'($signed(acc_re)), exp_re[k]);
        check($sformatf("bin%0d_im", k), int'($signed(acc_im)), exp_im[k]);
        check($sformatf("bin%0d_latency", k), cyc, cyc_exp);
        check($sformatf("bin%0d_enable_cycles", k), en, 4);
        check($sformatf("bin%0d_load_cycles", k), ld, 1);
    endtask

    task automatic run_frame(input logic [3:0][7:0] x, input logic junk);
        int cyc, en, ld;
        bin_ready = 1'b1;
        leak  = 0;
        dl_nz = 0;
        for (int n = 0; n < 4; n++) send_sample(x[n]);
        in_valid = junk;
        in_data  = 8'h55;
        for (int k = 0; k < 4; k++) begin
            wait_bin(cyc, en, ld);
            check_bin(k, 5, cyc, en, ld);
            check($sformatf("frame_done_bin%0d", k), int'(frame_done), (k == 3) ? 1 : 0);
            if (k == 3) in_valid = 1'b0;
        end
        @(negedge clk);
        check("post_frame_in_ready", int'(in_ready), 1);
        check("post_frame_done_low", int'(frame_done), 0);
        check("post_frame_bin_valid", int'(bin_valid), 0);
        check("no_ready_outside_idle", leak, 0);
        check("data_load_zero", dl_nz, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc, en, ld, stable;
        logic [3:0][7:0] x;

        // x[0] is the rightmost element of each concatenation
        vecs[0].x = {8'd4, 8'd3, 8'd2, 8'd1};
        vecs[0].re = '{10, -2, -2, -2};
        vecs[0].im = '{0, 2, 0, -2};
        vecs[1].x = {8'd0, 8'd0, 8'd0, 8'd5};
        vecs[1].re = '{5, 5, 5, 5};
        vecs[1].im = '{0, 0, 0, 0};
        vecs[2].x = {4{8'd127}};
        vecs[2].re = '{508, 0, 0, 0};
        vecs[2].im = '{0, 0, 0, 0};
        vecs[3].x = {4{8'h80}};
        vecs[3].re = '{-512, 0, 0, 0};
        vecs[3].im = '{0, 0, 0, 0};

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        bin_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_acc_enable", int'(acc_enable), 0);
        check("rst_bin_valid", int'(bin_valid), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_bin_idx", int'(bin_idx), 0);
        check("rst_acc_load", int'(acc_load), 0);
        rst = 1'b1;
        bin_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_bin_ready_ignored", int'(bin_valid), 0);
        check("idle_in_ready", int'(in_ready), 1);

        // Table-driven frames
        for (int i = 0; i < 4; i++) begin
            exp_re = vecs[i].re;
            exp_im = vecs[i].im;
            run_frame(vecs[i].x, 1'b0);
        end

        // Random frames checked against the reference DFT; odd ones keep in_valid high
        for (int i = 0; i < 6; i++) begin
            for (int n = 0; n < 4; n++) x[n] = 8'($urandom);
            ref_dft(x);
            run_frame(x, i[0]);
        end

        // Bin 1 stalled for 7 cycles
        x = {8'hF0, 8'd33, 8'hC5, 8'd77};
        ref_dft(x);
        bin_ready = 1'b1;
        for (int n = 0; n < 4; n++) send_sample(x[n]);
        wait_bin(cyc, en, ld);
        check_bin(0, 5, cyc, en, ld);
        @(posedge clk);
        #1 bin_ready = 1'b0;
        wait_bin(cyc, en, ld);
        check_bin(1, 5, cyc, en, ld);
        stable = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (bin_valid && bin_idx == 2'd1 && !acc_enable && !frame_done &&
                int'($signed(acc_re)) == exp_re[1] && int'($signed(acc_im)) == exp_im[1]) stable++;
        end
        check("stall_stable_cycles", stable, 7);
        bin_ready = 1'b1;
        for (int k = 2; k < 4; k++) begin
            wait_bin(cyc, en, ld);
            check_bin(k, 5, cyc, en, ld);
        end
        check("stall_frame_done", int'(frame_done), 1);

        // Reset in the middle of bin 2's RUN, then a clean frame
        x = {8'd9, 8'hFE, 8'd60, 8'h81};
        ref_dft(x);
        for (int n = 0; n < 4; n++) send_sample(x[n]);
        for (int k = 0; k < 2; k++) begin
            wait_bin(cyc, en, ld);
            check_bin(k, 5, cyc, en, ld);
        end
        repeat (2) @(negedge clk);
        check("mid_run_enable", int'(acc_enable), 1);
        rst = 1'b0;
        #1;
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_bin_valid", int'(bin_valid), 0);
        check("reset_acc_enable", int'(acc_enable), 0);
        @(negedge clk);
        check("reset_hold_bin_valid", int'(bin_valid), 0);
        rst = 1'b1;
        exp_re = vecs[0].re;
        exp_im = vecs[0].im;
        run_frame(vecs[0].x, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
